// File: rtl/vector_check_sequencer.sv
// vector_check_sequencer: walks a vector ROM, drives a combinational DUT, checks and counts mismatches
module vector_check_sequencer #(
  parameter int NIN    = 3,
  parameter int NOUT   = 1,
  parameter int AW     = 4,
  parameter int SETTLE = 1,
  parameter int CW     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic [AW-1:0]       vec_addr,
  input  logic [NIN+NOUT-1:0] vec_data,
  input  logic                vec_valid,
  output logic [NIN-1:0]      dut_in,
  input  logic [NOUT-1:0]     dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                err_pulse,
  output logic [AW-1:0]       err_index,
  output logic [CW-1:0]       err_count,
  output logic [CW-1:0]       vec_count
);
  localparam int SW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SETTLE, S_CHECK, S_DONE} state_t;
  state_t state, nxt;
  logic [SW-1:0] cnt;
  logic [NOUT-1:0] exp_q;
  logic mism;
  assign mism = dut_out != exp_q;
  assign busy = state == S_FETCH || state == S_SETTLE || state == S_CHECK;
  assign done = state == S_DONE;
  assign pass = done && err_count == '0;
  // state register; active-low reset aborts any run
  always_ff @(posedge clk)
    if (!reset) state <= S_IDLE;
    else state <= nxt;
  // next-state: start only honoured when idle or done; last ROM address ends the run without wrapping
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE, S_DONE: nxt = start ? S_FETCH : state;
      S_FETCH:        nxt = vec_valid ? S_SETTLE : S_DONE;
      S_SETTLE:       nxt = cnt == '0 ? S_CHECK : S_SETTLE;
      S_CHECK:        nxt = &vec_addr ? S_DONE : S_FETCH;
      default:        nxt = S_IDLE;
    endcase
  end
  // datapath: vector latch, settle countdown, compare and counters
  always_ff @(posedge clk)
    if (!reset) begin
      vec_addr  <= '0;
      dut_in    <= '0;
      exp_q     <= '0;
      cnt       <= '0;
      err_pulse <= 1'b0;
      err_index <= '0;
      err_count <= '0;
      vec_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE, S_DONE:
          if (start) begin
            vec_addr  <= '0;
            err_count <= '0;
            vec_count <= '0;
          end
        S_FETCH:
          if (vec_valid) begin
            dut_in <= vec_data[NIN+NOUT-1:NOUT];
            exp_q  <= vec_data[NOUT-1:0];
            cnt    <= SW'(SETTLE - 1);
          end
        S_SETTLE:
          if (cnt != '0) cnt <= cnt - 1'b1;
        S_CHECK: begin
          vec_count <= vec_count + 1'b1;
          if (mism) begin
            err_pulse <= 1'b1;
            err_index <= vec_addr;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
          if (!(&vec_addr)) vec_addr <= vec_addr + 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_vector_check_sequencer.sv
// tb_vector_check_sequencer: table-driven and randomized checks of the vector sequencer
module tb_vector_check_sequencer;
  logic clk = 0, reset = 0, start = 0;
  logic [3:0] vec_addr, vec_data;
  logic vec_valid;
  logic [2:0] dut_in;
  logic [0:0] dut_out;
  logic busy, done, pass, err_pulse;
  logic [3:0] err_index;
  logic [15:0] err_count, vec_count;
  logic [3:0] rom_data [16];
  logic rom_valid [16];
  int tests = 0, fails = 0;

  vector_check_sequencer #(.NIN(3), .NOUT(1), .AW(4), .SETTLE(1), .CW(16)) dut (
    .clk(clk), .reset(reset), .start(start), .vec_addr(vec_addr), .vec_data(vec_data),
    .vec_valid(vec_valid), .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .err_pulse(err_pulse), .err_index(err_index), .err_count(err_count),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;
  always_comb begin
    vec_data  = rom_data[vec_addr];
    vec_valid = rom_valid[vec_addr];
  end
  assign dut_out = ~dut_in[1] & ~dut_in[0];

  typedef struct {
    int nvalid; logic [15:0] corrupt; int glitch;
    int cycles; int vcnt; int ecnt; int eidx; bit ps;
  } vec_t;

  task automatic chk(input string name, input int got, input int expv);
    tests++;
    if (got != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  function automatic logic fn(input logic [2:0] x);
    return ~x[1] & ~x[0];
  endfunction

  task automatic load(input int nvalid, input logic [15:0] corrupt);
    for (int i = 0; i < 16; i++) begin
      logic [2:0] x;
      x = 3'(i % 8);
      rom_data[i]  = {x, fn(x) ^ corrupt[i]};
      rom_valid[i] = i < nvalid;
    end
  endtask

  task automatic run(input int glitch, output int cyc, output int pulses);
    @(negedge clk);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    cyc = 1;
    pulses = 0;
    while (!done && cyc < 200) begin
      if (err_pulse) pulses++;
      start = (cyc == glitch);
      @(posedge clk); #1;
      start = 0;
      cyc++;
    end
    if (err_pulse) pulses++;
  endtask

  task automatic verify(input string tag, input int nvalid, input int cyc, input int pulses,
                        input int ecyc, input int evc, input int eec, input int eidx, input bit eps);
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " cycles"}, cyc, ecyc);
    chk({tag, " vec_count"}, int'(vec_count), evc);
    chk({tag, " err_count"}, int'(err_count), eec);
    chk({tag, " pulses"}, pulses, eec);
    chk({tag, " pass"}, int'(pass), int'(eps));
    if (eec > 0) chk({tag, " err_index"}, int'(err_index), eidx);
    if (nvalid > 0) chk({tag, " dut_in"}, int'(dut_in), (nvalid - 1) % 8);
    if (nvalid == 16) chk({tag, " vec_addr"}, int'(vec_addr), 15);
  endtask

  vec_t tbl [6];
  int cyc, pulses;

  initial begin
    tbl[0] = '{8,  16'h0000, 0,  26, 8,  0, 0, 1'b1};
    tbl[1] = '{8,  16'h0020, 0,  26, 8,  1, 5, 1'b0};
    tbl[2] = '{16, 16'h0000, 0,  49, 16, 0, 0, 1'b1};
    tbl[3] = '{0,  16'h0000, 0,  2,  0,  0, 0, 1'b1};
    tbl[4] = '{8,  16'h0000, 7,  26, 8,  0, 0, 1'b1};
    tbl[5] = '{12, 16'h0204, 20, 38, 12, 2, 9, 1'b0};
    load(8, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset pass", int'(pass), 0);
    chk("reset vec_addr", int'(vec_addr), 0);
    chk("reset err_count", int'(err_count), 0);
    @(negedge clk);
    reset = 1;
    for (int t = 0; t < 6; t++) begin
      load(tbl[t].nvalid, tbl[t].corrupt);
      run(tbl[t].glitch, cyc, pulses);
      verify($sformatf("tbl%0d", t), tbl[t].nvalid, cyc, pulses, tbl[t].cycles,
             tbl[t].vcnt, tbl[t].ecnt, tbl[t].eidx, tbl[t].ps);
    end
    run(0, cyc, pulses);
    verify("repeat", 12, cyc, pulses, 38, 12, 2, 9, 1'b0);
    for (int r = 0; r < 20; r++) begin
      int n, e, idx;
      logic [15:0] c;
      n = int'($urandom_range(0, 16));
      c = 16'($urandom) & 16'($urandom);
      e = 0;
      idx = 0;
      for (int i = 0; i < n; i++)
        if (c[i]) begin e++; idx = i; end
      load(n, c);
      run(0, cyc, pulses);
      verify($sformatf("rnd%0d", r), n, cyc, pulses, 1 + 3 * n + (n < 16 ? 1 : 0), n, e, idx, e == 0);
    end
    load(8, 16'h0002);
    @(negedge clk);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("pre-abort vec_addr", int'(vec_addr), 3);
    chk("pre-abort err_count", int'(err_count), 1);
    @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort pass", int'(pass), 0);
    chk("abort err_pulse", int'(err_pulse), 0);
    chk("abort vec_addr", int'(vec_addr), 0);
    chk("abort dut_in", int'(dut_in), 0);
    chk("abort err_index", int'(err_index), 0);
    chk("abort err_count", int'(err_count), 0);
    chk("abort vec_count", int'(vec_count), 0);
    @(negedge clk);
    reset = 1;
    load(8, 0);
    run(0, cyc, pulses);
    verify("fresh", 8, cyc, pulses, 26, 8, 0, 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
